mmr_noc_tx: RTL and testbench

//  Downstream consumer of the WB-stage MMR write port (loadnoc path). Captures each

---
 rtl/mmr_noc_tx.sv | 179 +++++++++++++++++
 tb/tb_mmr_noc_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmr_noc_tx.sv
`default_nettype none
// ============================================================================
//  Module  : mmr_noc_tx
//  Purpose : Captures loadnoc MMR writes that hit the NoC window, buffers them
//            in a small FIFO and serialises each one into a 3-flit packet
//            (head/body/tail) on a valid/ready link.
//  Ports   : clk, reset (async, active-low)
//            mmr_we, mmr_location[31:0], loadnoc_data[31:0]  - WB-stage write
//            noc_ready, noc_valid, noc_flit[17:0]            - NoC link
//            clr_ovf, overflow                               - sticky drop flag
//            fifo_full, fifo_count                           - back-pressure
//            pkt_sent[15:0]                                  - packets completed
//  Rev     : 1.0  initial release
// ============================================================================
module mmr_noc_tx #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] NOC_BASE   = 32'h0000_F000,
    parameter logic [7:0]  SRC_ID     = 8'h00
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mmr_we,
    input  logic [31:0]                   mmr_location,
    input  logic [31:0]                   loadnoc_data,
    input  logic                          noc_ready,
    input  logic                          clr_ovf,
    output logic                          noc_valid,
    output logic [17:0]                   noc_flit,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [15:0]                   pkt_sent
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_BODY = 2'd2,
        S_TAIL = 2'd3
    } state_t;

    // Entry layout: {dest[7:0], payload[31:0]}
    logic [39:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_full;
    logic            r_overflow;
    logic [15:0]     r_pkt_sent;
    state_t          r_state;
    logic            r_valid;
    logic [17:0]     r_flit;

    state_t          w_state_nxt;
    logic            w_valid_nxt;
    logic [17:0]     w_flit_nxt;
    logic            w_hit;
    logic            w_accept;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [c_CW-1:0] w_count_nxt;
    logic [39:0]     w_cur;
    logic [39:0]     w_next_entry;
    logic [39:0]     w_in_entry;

    assign w_hit      = mmr_we && (mmr_location[31:8] == NOC_BASE[31:8]);
    assign w_accept   = r_valid && noc_ready;
    // A packet only leaves the FIFO once its tail flit is accepted.
    assign w_pop      = (r_state == S_TAIL) && w_accept;
    // A full FIFO still takes a write if the tail pop frees a slot on this edge.
    assign w_push     = w_hit && ((r_count != c_CW'(FIFO_DEPTH)) || w_pop);
    assign w_drop     = w_hit && !w_push;
    assign w_count_nxt = r_count + c_CW'(w_push) - c_CW'(w_pop);
    assign w_in_entry = {mmr_location[7:0], loadnoc_data};
    assign w_cur      = r_mem[r_rd_ptr];
    // Entry that follows the one being popped; when the FIFO held only one
    // entry, the follower can only be the write arriving on this same edge.
    assign w_next_entry = (r_count > c_CW'(1)) ? r_mem[r_rd_ptr + c_AW'(1)] : w_in_entry;

    // FIFO storage carries no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
            r_pkt_sent <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_CW'(FIFO_DEPTH));
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
            if (w_pop) r_pkt_sent <= r_pkt_sent + 16'd1;
        end
    end

    // Link FSM state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_flit  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_flit  <= w_flit_nxt;
        end
    end

    // Next-state logic: outputs hold unless the current flit is accepted,
    // which keeps flit/valid stable under back-pressure.
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_flit_nxt  = r_flit;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = S_HEAD;
                    w_valid_nxt = 1'b1;
                    w_flit_nxt  = {2'b01, w_cur[39:32], SRC_ID};
                end
            end
            S_HEAD: begin
                if (w_accept) begin
                    w_state_nxt = S_BODY;
                    w_flit_nxt  = {2'b00, w_cur[15:0]};
                end
            end
            S_BODY: begin
                if (w_accept) begin
                    w_state_nxt = S_TAIL;
                    w_flit_nxt  = {2'b10, w_cur[31:16]};
                end
            end
            S_TAIL: begin
                if (w_accept) begin
                    if (w_count_nxt != '0) begin
                        // Chain straight into the next packet, no idle bubble.
                        w_state_nxt = S_HEAD;
                        w_flit_nxt  = {2'b01, w_next_entry[39:32], SRC_ID};
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign noc_valid  = r_valid;
    assign noc_flit   = r_flit;
    assign fifo_full  = r_full;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign pkt_sent   = r_pkt_sent;

endmodule
`default_nettype wire

// File: tb/tb_mmr_noc_tx.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mmr_noc_tx
//  Purpose : Self-checking bench for mmr_noc_tx. Directed scenarios followed by
//            randomized traffic, all compared against a packet-queue model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mmr_noc_tx;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_F000;
    localparam logic [7:0]  SRC   = 8'h00;

    logic        clk = 1'b0;
    logic        reset;
    logic        mmr_we;
    logic [31:0] mmr_location;
    logic [31:0] loadnoc_data;
    logic        noc_ready;
    logic        clr_ovf;
    logic        noc_valid;
    logic [17:0] noc_flit;
    logic        fifo_full;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic [15:0] pkt_sent;

    mmr_noc_tx #(
        .FIFO_DEPTH (DEPTH),
        .NOC_BASE   (BASE),
        .SRC_ID     (SRC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mmr_we       (mmr_we),
        .mmr_location (mmr_location),
        .loadnoc_data (loadnoc_data),
        .noc_ready    (noc_ready),
        .clr_ovf      (clr_ovf),
        .noc_valid    (noc_valid),
        .noc_flit     (noc_flit),
        .fifo_full    (fifo_full),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .pkt_sent     (pkt_sent)
    );

    always #5 clk = ~clk;

    // Reference model: queue of pending packets, whether a packet is on the
    // link, and which of its three flits is currently offered.
    logic [39:0] q[$];
    bit          m_in;
    int          m_idx;
    bit          m_ovf;
    logic [15:0] m_pkt;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] exp_flit();
        logic [39:0] e;
        e = q[0];
        case (m_idx)
            0:       return {2'b01, e[39:32], SRC};
            1:       return {2'b00, e[15:0]};
            default: return {2'b10, e[31:16]};
        endcase
    endfunction

    task automatic model_clear();
        q.delete();
        m_in  = 0;
        m_idx = 0;
        m_ovf = 0;
        m_pkt = '0;
    endtask

    task automatic model_edge(input logic we, input logic [31:0] loc,
                              input logic [31:0] data, input logic rdy, input logic clr);
        bit hit, pop, push_ok;
        int sz;
        sz  = q.size();
        hit = we && ((loc >> 8) == (BASE >> 8));
        pop = 0;
        if (m_in && rdy) begin
            if (m_idx == 2) pop = 1;
            else            m_idx++;
        end
        if (pop) begin
            void'(q.pop_front());
            m_pkt = m_pkt + 16'd1;
        end
        push_ok = hit && (sz < DEPTH || pop);
        if (push_ok) q.push_back({loc[7:0], data});
        if (hit && !push_ok) m_ovf = 1;
        else if (clr)        m_ovf = 0;
        if (pop) begin
            m_idx = 0;
            m_in  = (q.size() > 0);
        end else if (!m_in && sz > 0) begin
            m_in  = 1;
            m_idx = 0;
        end
    endtask

    task automatic check_outputs();
        chk("valid", 32'(noc_valid), 32'(m_in));
        if (m_in) chk("flit", 32'(noc_flit), 32'(exp_flit()));
        chk("full", 32'(fifo_full), 32'(q.size() == DEPTH));
        chk("count", 32'(fifo_count), 32'(q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("pkt_sent", 32'(pkt_sent), 32'(m_pkt));
    endtask

    // One clock: drive inputs, let the edge happen, update the model, and
    // compare on the falling edge.
    task automatic cycle(input logic we, input logic [31:0] loc,
                         input logic [31:0] data, input logic rdy, input logic clr);
        mmr_we       = we;
        mmr_location = loc;
        loadnoc_data = data;
        noc_ready    = rdy;
        clr_ovf      = clr;
        @(posedge clk);
        model_edge(we, loc, data, rdy, clr);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, rdy, 1'b0);
    endtask

    task automatic push(input logic [7:0] dest, input logic [31:0] data, input logic rdy);
        cycle(1'b1, BASE | 32'(dest), data, rdy, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(noc_valid), 32'h0);
        chk({tag, "_flit"}, 32'(noc_flit), 32'h0);
        chk({tag, "_full"}, 32'(fifo_full), 32'h0);
        chk({tag, "_count"}, 32'(fifo_count), 32'h0);
        chk({tag, "_ovf"}, 32'(overflow), 32'h0);
        chk({tag, "_pkt"}, 32'(pkt_sent), 32'h0);
    endtask

    // Asserts reset between clock edges and checks it acts without an edge.
    task automatic async_reset(input string tag);
        mmr_we    = 1'b0;
        noc_ready = 1'b0;
        clr_ovf   = 1'b0;
        #2 reset = 1'b0;
        #1 check_zero(tag);
        model_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bit done;
        reset        = 1'b0;
        mmr_we       = 1'b0;
        mmr_location = '0;
        loadnoc_data = '0;
        noc_ready    = 1'b0;
        clr_ovf      = 1'b0;
        model_clear();

        // Reset at power-up, then release
        #1 check_zero("por");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(1'b1, 2);

        // Single packet, link always ready
        push(8'h05, 32'hDEAD_BEEF, 1'b1);
        chk("sp_latency_valid", 32'(noc_valid), 32'h0);
        idle(1'b1, 1);
        chk("sp_head", 32'(noc_flit), 32'h1_0500);
        idle(1'b1, 1);
        chk("sp_body", 32'(noc_flit), 32'h0_BEEF);
        idle(1'b1, 1);
        chk("sp_tail", 32'(noc_flit), 32'h2_DEAD);
        idle(1'b1, 1);
        chk("sp_done_valid", 32'(noc_valid), 32'h0);
        chk("sp_pkt", 32'(pkt_sent), 32'h1);

        // Back-pressure during BODY
        push(8'h05, 32'hDEAD_BEEF, 1'b1);
        idle(1'b1, 2);
        for (int i = 0; i < 5; i++) begin
            idle(1'b0, 1);
            chk("bp_hold_flit", 32'(noc_flit), 32'h0_BEEF);
            chk("bp_hold_valid", 32'(noc_valid), 32'h1);
        end
        idle(1'b1, 1);
        chk("bp_tail", 32'(noc_flit), 32'h2_DEAD);
        idle(1'b1, 2);

        // Reset mid-packet: partial packet discarded
        push(8'h33, 32'h1234_5678, 1'b1);
        idle(1'b1, 2);
        async_reset("midpkt");
        idle(1'b1, 3);
        chk("midpkt_no_resume", 32'(noc_valid), 32'h0);

        // Overflow: five writes with the link stalled
        for (int i = 0; i < 5; i++) begin
            push(8'(8'h10 + i), 32'hA000_0000 + 32'(i), 1'b0);
            if (i == 3) chk("ovf_full_after4", 32'(fifo_full), 32'h1);
        end
        chk("ovf_set", 32'(overflow), 32'h1);
        // Simultaneous drop and clear: the set wins
        cycle(1'b1, BASE | 32'h77, 32'hBAD0_BAD0, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(overflow), 32'h1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("ovf_clear", 32'(overflow), 32'h0);
        idle(1'b1, 14);
        chk("ovf_drained", 32'(fifo_count), 32'h0);

        // Full FIFO, push lands on the tail-accept edge
        for (int i = 0; i < 4; i++) push(8'(8'h20 + i), 32'hC000_0000 + 32'(i), 1'b0);
        done = 0;
        for (int i = 0; i < 20; i++) begin
            if (!done && m_in && m_idx == 2) begin
                cycle(1'b1, BASE | 32'h2F, 32'hC0DE_0004, 1'b1, 1'b0);
                chk("fp_count", 32'(fifo_count), 32'h4);
                chk("fp_no_ovf", 32'(overflow), 32'h0);
                chk("fp_no_bubble", 32'(noc_valid), 32'h1);
                done = 1;
            end else begin
                idle(1'b1, 1);
            end
        end
        chk("fp_hit", 32'(done), 32'h1);
        idle(1'b1, 4);

        // Address filter and packet counter wrap
        cycle(1'b1, BASE + 32'h100, 32'h5555_5555, 1'b1, 1'b0);
        chk("filter_count", 32'(fifo_count), 32'h0);
        force dut.r_pkt_sent = 16'hFFFF;
        #1 release dut.r_pkt_sent;
        #1 m_pkt = 16'hFFFF;
        chk("wrap_preload", 32'(pkt_sent), 32'hFFFF);
        @(negedge clk);
        push(8'h01, 32'h0BAD_F00D, 1'b1);
        idle(1'b1, 4);
        chk("wrap_zero", 32'(pkt_sent), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] loc;
            loc = ($urandom_range(0, 7) == 0) ? 32'($urandom)
                                              : (BASE | 32'($urandom_range(0, 255)));
            cycle(1'($urandom_range(0, 1)), loc, 32'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end
        idle(1'b1, 16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
